// File: rtl/controlador_boot.sv
// Boot source controller: hands instruction fetch between BIOS ROM and main memory,
// issuing a fixed-width CPU reset pulse and a NOP stream while the switch is in progress.
module controlador_boot #(
  parameter int          WIDTH      = 32,
  parameter logic [5:0]  HANDOFF_OP = 6'b011000,
  parameter logic [5:0]  RETURN_OP  = 6'b011001,
  parameter int          RST_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bios,
  input  logic             bios_valid,
  input  logic [WIDTH-1:0] mem,
  input  logic             mem_valid,
  input  logic             ret_en,
  output logic [WIDTH-1:0] out,
  output logic             cpu_reset,
  output logic             sel,
  output logic             busy,
  output logic [7:0]       switch_cnt
);

  typedef enum logic [1:0] {
    ST_BIOS   = 2'd0,
    ST_SWITCH = 2'd1,
    ST_MEM    = 2'd2
  } state_t;

  localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES - 1);

  state_t     state_q, state_d;
  logic       target_q, target_d;   // 1 = MEMORY once the pulse completes
  logic [7:0] cnt_q, cnt_d;
  logic       cpu_reset_q, cpu_reset_d;
  logic [7:0] switch_cnt_q, switch_cnt_d;
  logic       start;

  logic [5:0] bios_op;
  logic [5:0] mem_op;
  assign bios_op = bios[WIDTH-1 -: 6];
  assign mem_op  = mem[WIDTH-1 -: 6];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BIOS;
      target_q     <= 1'b0;
      cnt_q        <= 8'd0;
      cpu_reset_q  <= 1'b0;
      switch_cnt_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      cnt_q        <= cnt_d;
      cpu_reset_q  <= cpu_reset_d;
      switch_cnt_q <= switch_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    cnt_d        = cnt_q;
    cpu_reset_d  = cpu_reset_q;
    switch_cnt_d = switch_cnt_q;
    start        = 1'b0;
    case (state_q)
      ST_BIOS: begin
        if (bios_valid && (bios_op == HANDOFF_OP)) begin
          start    = 1'b1;
          target_d = 1'b1;
        end
      end
      ST_MEM: begin
        if (mem_valid && ret_en && (mem_op == RETURN_OP)) begin
          start    = 1'b1;
          target_d = 1'b0;
        end
      end
      ST_SWITCH: begin
        // Triggers are deliberately not looked at here: the pulse cannot be extended.
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d     = target_q ? ST_MEM : ST_BIOS;
          cpu_reset_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_BIOS;
        cpu_reset_d = 1'b0;
      end
    endcase
    if (start) begin
      state_d     = ST_SWITCH;
      cpu_reset_d = 1'b1;
      cnt_d       = RST_LOAD;
      if (switch_cnt_q != 8'hFF) begin
        switch_cnt_d = switch_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    out  = bios;
    sel  = 1'b0;
    busy = 1'b0;
    case (state_q)
      ST_MEM: begin
        out = mem;
        sel = 1'b1;
      end
      ST_SWITCH: begin
        out  = '0;
        busy = 1'b1;
      end
      default: begin
        out = bios;
      end
    endcase
  end

  assign cpu_reset  = cpu_reset_q;
  assign switch_cnt = switch_cnt_q;

endmodule

// File: doc/controlador_boot.md
CONTROLADOR_BOOT -- requirements
Module: controlador_boot

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning instruction width in bits (minimum 8).
REQ-002 The block SHALL have parameter HANDOFF_OP, default 6'b011000, meaning the opcode in bits [WIDTH-1:WIDTH-6] that hands off from BIOS to memory.
REQ-003 The block SHALL have parameter RETURN_OP, default 6'b011001, meaning the opcode in bits [WIDTH-1:WIDTH-6] that returns from memory to BIOS.
REQ-004 The block SHALL have parameter RST_CYCLES, default 4, meaning the width in cycles of the cpu_reset pulse (range 1..255).
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on posedge.
REQ-006 The block SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-007 The block SHALL have port bios, input, WIDTH bits, the instruction word from BIOS ROM.
REQ-008 The block SHALL have port bios_valid, input, 1 bit, meaning the bios word is a valid fetch this cycle.
REQ-009 The block SHALL have port mem, input, WIDTH bits, the instruction word from main memory.
REQ-010 The block SHALL have port mem_valid, input, 1 bit, meaning the mem word is a valid fetch this cycle.
REQ-011 The block SHALL have port ret_en, input, 1 bit, which enables RETURN_OP decoding.
REQ-012 The block SHALL have port out, output, WIDTH bits, the effective instruction.
REQ-013 The block SHALL have port cpu_reset, output, 1 bit, the active-high reset pulse to the CPU pipeline.
REQ-014 The block SHALL have port sel, output, 1 bit, the current source (0 = BIOS, 1 = MEMORY).
REQ-015 The block SHALL have port busy, output, 1 bit, high while a switch is in progress.
REQ-016 The block SHALL have port switch_cnt, output, 8 bits, a saturating count of switches started.

Function
REQ-017 The FSM SHALL have three states: BIOS, SWITCH and MEMORY, plus a 1-bit target register and an 8-bit pulse counter.
REQ-018 In BIOS, a posedge with bios_valid=1 and bios opcode == HANDOFF_OP SHALL move the FSM to SWITCH, set target=MEMORY, set cpu_reset=1 and load counter=RST_CYCLES-1.
REQ-019 In MEMORY, a posedge with mem_valid=1, ret_en=1 and mem opcode == RETURN_OP SHALL move the FSM to SWITCH, set target=BIOS, set cpu_reset=1 and load counter=RST_CYCLES-1.
REQ-020 In MEMORY, a RETURN_OP with ret_en=0, or any opcode with mem_valid=0, SHALL be ignored.
REQ-021 In BIOS, a HANDOFF_OP with bios_valid=0 SHALL be ignored.
REQ-022 In SWITCH with counter != 0, each posedge SHALL decrement the counter.
REQ-023 In SWITCH with counter == 0, the posedge SHALL move the FSM to target and clear cpu_reset.
REQ-024 cpu_reset SHALL be registered and high for exactly RST_CYCLES consecutive cycles per switch; RST_CYCLES=1 gives a single-cycle pulse.
REQ-025 All opcodes and valid inputs SHALL be ignored while in SWITCH; no re-trigger and no pulse extension.
REQ-026 out SHALL be combinational: bios in BIOS, mem in MEMORY, all zeros (NOP) in SWITCH.
REQ-027 sel SHALL be 1 only in MEMORY; busy SHALL be 1 only in SWITCH.
REQ-028 switch_cnt SHALL increment on every entry into SWITCH and saturate at 255.
REQ-029 Only bits [WIDTH-1:WIDTH-6] SHALL be compared against HANDOFF_OP and RETURN_OP; the remaining bits SHALL be don't-care.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state=BIOS, target=BIOS, counter=0, cpu_reset=0 and switch_cnt=0.
REQ-031 While rst_n=0, outputs SHALL be out=bios, sel=0 and busy=0.
REQ-032 Reset asserted mid-SWITCH SHALL abort the switch immediately, with no residual pulse after release.
REQ-033 After rst_n rises, the first decode SHALL occur at the next posedge.

Verification
REQ-034 Handoff: with defaults, bios=32'h6000_0000 and bios_valid=1 for 1 cycle -> cpu_reset high for exactly 4 cycles, out=0 during the pulse, then sel=1, out=mem, switch_cnt=1.
REQ-035 Gated return: in MEMORY, mem=32'h6400_0000, mem_valid=1, ret_en=0 -> no change; repeat with ret_en=1 -> 4-cycle pulse, then sel=0, out=bios, switch_cnt=2.
REQ-036 Invalid and mid-switch triggers: a HANDOFF word with bios_valid=0 -> stays in BIOS; a HANDOFF word held valid throughout SWITCH -> pulse stays exactly 4 cycles and switch_cnt increments by 1 only.
REQ-037 Async reset mid-switch: drop rst_n during the 2nd pulse cycle, off clock edge -> cpu_reset=0, sel=0, busy=0 and switch_cnt=0 immediately; after release the block sits in BIOS.
REQ-038 Pulse width and saturation: with RST_CYCLES=1, a handoff gives a 1-cycle pulse; 300 alternating handoffs and returns -> switch_cnt=255.
REQ-039 Width: with WIDTH=16, bios=16'h6000 -> switch occurs; bios=16'h6400 in BIOS -> no switch.
